// File: rtl/rr_sel4.sv
// Round-robin selector driving the 2-bit select of a downstream 4:1 mux.
// Grants are held until done, request drop, or the hold limit; outputs are registered.
module rr_sel4 #(
   parameter int unsigned MAX_HOLD = 15,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [1:0] sel,
   output logic [3:0] grant,
   output logic       busy,
   output logic       timeout
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e           r_state;
   logic [1:0]       r_sel;
   logic [3:0]       r_grant;
   logic             r_busy;
   logic             r_timeout;
   logic [1:0]       r_ptr;
   logic [CNT_W-1:0] r_cnt;

   logic [1:0]       w_pick;
   logic             w_any;

   // Descending scan so the requester closest to r_ptr wins.
   always_comb begin
      w_pick = r_ptr;
      w_any  = |req;
      for (int k = 3; k >= 0; k--) begin
         if (req[r_ptr + 2'(k)]) begin
            w_pick = r_ptr + 2'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= StIdle;
         r_sel     <= 2'b00;
         r_grant   <= 4'b0000;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
         r_ptr     <= 2'b00;
         r_cnt     <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_any) begin
                  r_sel   <= w_pick;
                  r_grant <= 4'b0001 << w_pick;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= StGrant;
               end
            end
            StGrant: begin
               if (done || !req[r_sel]) begin
                  r_grant <= 4'b0000;
                  r_busy  <= 1'b0;
                  r_ptr   <= r_sel + 2'd1;
                  r_state <= StIdle;
               end else if (r_cnt == LIMIT) begin
                  r_grant   <= 4'b0000;
                  r_busy    <= 1'b0;
                  r_ptr     <= r_sel + 2'd1;
                  r_timeout <= 1'b1;
                  r_state   <= StIdle;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign sel     = r_sel;
   assign grant   = r_grant;
   assign busy    = r_busy;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_sel4.sv
// Self-checking bench for rr_sel4: cycle-level behavioural model plus directed
// scenarios with hand-computed expectations.
module tb_rr_sel4;

   localparam int MAX_HOLD = 15;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req;
   logic       done;
   logic [1:0] sel;
   logic [3:0] grant;
   logic       busy;
   logic       timeout;

   int checks   = 0;
   int failures = 0;

   rr_sel4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .done    (done),
      .sel     (sel),
      .grant   (grant),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: who owns the path, how many cycles it has been visible, next search start.
   bit         m_busy    = 0;
   logic [1:0] m_sel     = 2'd0;
   int         m_ptr     = 0;
   int         m_elapsed = 0;
   bit         m_to      = 0;
   bit         m_found;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy = 0; m_sel = 2'd0; m_ptr = 0; m_elapsed = 0; m_to = 0;
      end else begin
         m_to = 0;
         if (!m_busy) begin
            if (req != 4'd0) begin
               m_found = 0;
               for (int k = 0; k < 4; k++) begin
                  if (!m_found && req[(m_ptr + k) % 4]) begin
                     m_sel   = 2'((m_ptr + k) % 4);
                     m_found = 1;
                  end
               end
               m_busy    = 1;
               m_elapsed = 1;
            end
         end else if (done || !req[m_sel]) begin
            m_busy = 0;
            m_ptr  = (int'(m_sel) + 1) % 4;
         end else if (m_elapsed == MAX_HOLD) begin
            m_busy = 0;
            m_ptr  = (int'(m_sel) + 1) % 4;
            m_to   = 1;
         end else begin
            m_elapsed++;
         end
      end
   end

   always @(negedge clk) begin
      chk("model_sel", 32'(sel), 32'(m_sel));
      chk("model_grant", 32'(grant), m_busy ? 32'(1) << m_sel : 32'd0);
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_timeout", 32'(timeout), 32'(m_to));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] fair_seq [5];

   initial begin
      fair_seq[0] = 4'b0001; fair_seq[1] = 4'b0010; fair_seq[2] = 4'b0100;
      fair_seq[3] = 4'b1000; fair_seq[4] = 4'b0001;
      reset_n = 1'b1; req = 4'd0; done = 1'b0;
      #1 reset_n = 1'b0;
      step(); step();
      chk("rst_sel", 32'(sel), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_timeout", 32'(timeout), 0);
      reset_n = 1'b1;
      step();

      // Fairness from ptr=0 with all sources requesting.
      req = 4'b1111;
      step();
      chk("fair_grant0", 32'(grant), 32'(fair_seq[0]));
      for (int i = 1; i < 5; i++) begin
         done = 1'b1;
         step();
         done = 1'b0;
         chk("fair_gap", 32'(grant), 0);
         step();
         chk("fair_grant", 32'(grant), 32'(fair_seq[i]));
      end
      done = 1'b1; step(); done = 1'b0; req = 4'd0;
      step();

      // Single request, then done pulse.
      req = 4'b0010;
      step();
      chk("single_sel", 32'(sel), 1);
      chk("single_grant", 32'(grant), 32'b0010);
      chk("single_busy", 32'(busy), 1);
      done = 1'b1;
      step();
      done = 1'b0; req = 4'd0;
      chk("single_rel_grant", 32'(grant), 0);
      chk("single_rel_busy", 32'(busy), 0);
      chk("single_rel_sel", 32'(sel), 1);
      step();

      // Pointer wrap: owner 3, then 0, then 3.
      req = 4'b1000;
      step();
      chk("wrap_own3", 32'(grant), 32'b1000);
      req = 4'd0;
      step();
      req = 4'b1001;
      step();
      chk("wrap_to0", 32'(grant), 32'b0001);
      done = 1'b1;
      step();
      done = 1'b0;
      step();
      chk("wrap_to3", 32'(grant), 32'b1000);
      chk("wrap_sel3", 32'(sel), 3);
      req = 4'd0;
      step();
      step();

      // Hold limit: 15 busy cycles, one-cycle timeout, regrant after one idle cycle.
      req = 4'b0001;
      step();
      chk("hold_start", 32'(busy), 1);
      for (int i = 1; i < MAX_HOLD; i++) begin
         step();
         chk("hold_busy", 32'(busy), 1);
      end
      step();
      chk("hold_rel_busy", 32'(busy), 0);
      chk("hold_timeout", 32'(timeout), 1);
      step();
      chk("hold_regrant", 32'(grant), 32'b0001);
      chk("hold_to_clear", 32'(timeout), 0);

      // done on the limit cycle wins: no timeout.
      for (int i = 1; i < MAX_HOLD; i++) step();
      chk("lim_still_busy", 32'(busy), 1);
      done = 1'b1;
      step();
      done = 1'b0; req = 4'd0;
      chk("lim_done_busy", 32'(busy), 0);
      chk("lim_done_to", 32'(timeout), 0);
      step();

      // Owner drops request mid-grant; pointer moves past it.
      req = 4'b0100;
      step();
      chk("drop_own2", 32'(grant), 32'b0100);
      step();
      req = 4'b0010;
      step();
      chk("drop_rel", 32'(busy), 0);
      step();
      chk("drop_next", 32'(grant), 32'b0010);

      // Reset mid-grant with source 2 requesting.
      req = 4'b0100;
      step();
      step();
      chk("rst2_pre", 32'(grant), 32'b0100);
      reset_n = 1'b0;
      #1;
      chk("rst2_sel", 32'(sel), 0);
      chk("rst2_grant", 32'(grant), 0);
      chk("rst2_busy", 32'(busy), 0);
      chk("rst2_timeout", 32'(timeout), 0);
      step();
      reset_n = 1'b1;
      step();
      chk("rst2_regrant", 32'(grant), 32'b0100);
      chk("rst2_sel2", 32'(sel), 2);
      req = 4'd0;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
